rf_exec_unit: RTL
=================

# rf_exec_unit

Multi-cycle execution sequencer that sits directly in front of the 4×16 register file. It accepts one instruction at a time over a valid/ready handshake and drives the register file's two read ports to fetch operands. It computes a 16-bit result, including an optional 16-cycle shift-add multiply, and writes the result back through the register file's single write port. It is both the register file's only reader and its only writer.

## Interface
- WIDTH, 16, datapath width; must match the register file word width.
- ADDR_W, 2, register address width (4 registers).
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- Instr_Valid  in  1  instruction present on the Opcode/Dest/Src1/Src2/Immediate inputs.
- Instr_Ready  out  1  high only in IDLE; an instruction is accepted on an edge where Instr_Valid & Instr_Ready.
- Opcode  in  3  operation select (see Operation).
- Dest, Src1, Src2  in  ADDR_W each  destination and source register numbers.
- Immediate  in  WIDTH  literal for LDI.
- Read_Address1, Read_Address2  out  ADDR_W  to register file read ports; registered copies of Src1/Src2.
- Read_Data1, Read_Data2  in  WIDTH  from register file (combinational read).
- Write_Enable  out  1  one-cycle write strobe to register file.
- Write_Address  out  ADDR_W  latched Dest.
- Write_Data  out  WIDTH  result register.
- Done  out  1  one-cycle pulse, coincident with Write_Enable.
- Error  out  1  one-cycle pulse on an unsupported opcode.
- Zero  out  1  registered; updated at write-back to (result == 0).

## Operation
- States: IDLE, READ, EXEC, MUL, WB.
- IDLE: on accept, latch all instruction fields and go to READ. With no accept, stay in IDLE. Field values are ignored when not accepted.
- READ: Read_Address1/2 already hold Src1/Src2. Capture Read_Data1/2 into operands A and B, then go to EXEC.
- EXEC: compute the result into R and go to WB. For MUL, initialise product=0, mcand=A, mplier=B, cnt=0 and go to MUL instead.
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND: A&B.
  - 011 OR: A|B.
  - 100 XOR: A^B.
  - 101 SHL: A << B[3:0].
  - 110 LDI: Immediate.
  - 111 MUL: low 16 bits of A×B.
- Arithmetic: all results are truncated modulo 2^16. No carry or overflow flags.
- MUL: one shift-add step per cycle.
  - If mplier[0] is set, add mcand to product. Then shift mcand left and mplier right.
  - After the 16th step (cnt==15), go to WB.
- WB: Write_Enable=1, Done=1, Write_Address=Dest, Write_Data=R. Zero is updated on the closing edge. Go to IDLE.
- Reset (any state, including mid-MUL): go to IDLE immediately with no write. All outputs 0 except Instr_Ready=1. All internal registers clear.

## Timing
- Accept edge at cycle k. READ in k+1, EXEC in k+2, WB in k+3. Register file is written on the edge ending k+3. Instr_Ready is high again in k+4.
- MUL: WB in k+19. Instr_Ready is low for cycles k+1 through k+19.
- Maximum throughput: one non-MUL instruction per 4 cycles.
- Back-to-back dependent instructions need no hazard logic: the write lands before the next READ (k+5 at the earliest).
- Write_Enable and Done are never high outside WB. Error is never high outside EXEC.

## Configuration
- RF_EXEC_MUL_EN defined: MUL state and multiplier datapath are compiled in; opcode 111 behaves as specified.
- RF_EXEC_MUL_EN undefined:
  - No MUL state or datapath is built.
  - Opcode 111 pulses Error in EXEC (cycle k+2) and returns to IDLE with no write and no Done. Instr_Ready is high at k+3.
  - Zero is unchanged.

## Test plan
- Reset, LDI r1=0x0005, LDI r2=0x0003, ADD r3=r1+r2 -> Write_Enable at accept+3, Write_Address=3, Write_Data=0x0008, Done pulse, Zero=0.
- SUB r0=r2−r1 -> Write_Data=0xFFFE. SUB r1=r1−r1 -> Write_Data=0x0000, Zero=1.
- SHL with r1=0x0001, r2=0x0013 -> 0x0008. XOR 0xF0F0^0x0FF0 -> 0xFF00.
- MUL r1=0x0100 × r2=0x0101 -> Write_Data=0x0100 at accept+19; Instr_Ready low for 19 cycles. Without RF_EXEC_MUL_EN: Error at accept+2, no Write_Enable, Instr_Ready=1 at accept+3.
- Instr_Valid held high with LDI r1=7 then ADD r2=r1+r1 -> second accepted at k+4, writes 0x000E at k+7.
- Reset asserted during MUL step 8 -> no Write_Enable or Done ever pulses, all outputs 0, Instr_Ready=1. The next LDI completes normally.

Source files
------------

// File: rtl/rf_exec_unit.sv
// rf_exec_unit: multi-cycle sequencer in front of a 4x16 register file.
// Accepts one instruction over Instr_Valid/Instr_Ready, reads operands through
// the register file's two read ports, computes a result and writes it back.
// Optional feature macro: RF_EXEC_MUL_EN builds the 16-step shift-add multiplier;
// without it opcode 111 raises Error in EXEC and returns to IDLE without a write.
module rf_exec_unit #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 2
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Instr_Valid,
   output logic              Instr_Ready,
   input  logic [2:0]        Opcode,
   input  logic [ADDR_W-1:0] Dest,
   input  logic [ADDR_W-1:0] Src1,
   input  logic [ADDR_W-1:0] Src2,
   input  logic [WIDTH-1:0]  Immediate,
   output logic [ADDR_W-1:0] Read_Address1,
   output logic [ADDR_W-1:0] Read_Address2,
   input  logic [WIDTH-1:0]  Read_Data1,
   input  logic [WIDTH-1:0]  Read_Data2,
   output logic              Write_Enable,
   output logic [ADDR_W-1:0] Write_Address,
   output logic [WIDTH-1:0]  Write_Data,
   output logic              Done,
   output logic              Error,
   output logic              Zero
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_LDI = 3'b110,
      OP_MUL = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      EXEC,
`ifdef RF_EXEC_MUL_EN
      MUL,
`endif
      WB
   } state_e;

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [ADDR_W-1:0] src1_q, src1_d;
   logic [ADDR_W-1:0] src2_q, src2_d;
   logic [WIDTH-1:0]  imm_q, imm_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  r_q, r_d;
   logic              zero_q, zero_d;

`ifdef RF_EXEC_MUL_EN
   localparam int unsigned CNT_W = $clog2(WIDTH);
   logic [WIDTH-1:0]  prod_q, prod_d;
   logic [WIDTH-1:0]  mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   assign Read_Address1 = src1_q;
   assign Read_Address2 = src2_q;
   assign Write_Address = dest_q;
   assign Write_Data    = r_q;
   assign Zero          = zero_q;

   // Next-state, datapath updates and per-state strobes
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      dest_d       = dest_q;
      src1_d       = src1_q;
      src2_d       = src2_q;
      imm_d        = imm_q;
      a_d          = a_q;
      b_d          = b_q;
      r_d          = r_q;
      zero_d       = zero_q;
`ifdef RF_EXEC_MUL_EN
      prod_d       = prod_q;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      cnt_d        = cnt_q;
`endif
      Instr_Ready  = 1'b0;
      Write_Enable = 1'b0;
      Done         = 1'b0;
      Error        = 1'b0;

      case (state_q)
         IDLE: begin
            Instr_Ready = 1'b1;
            if (Instr_Valid) begin
               op_d    = op_e'(Opcode);
               dest_d  = Dest;
               src1_d  = Src1;
               src2_d  = Src2;
               imm_d   = Immediate;
               state_d = READ;
            end
         end
         READ: begin
            a_d     = Read_Data1;
            b_d     = Read_Data2;
            state_d = EXEC;
         end
         EXEC: begin
            state_d = WB;
            case (op_q)
               OP_ADD: r_d = a_q + b_q;
               OP_SUB: r_d = a_q - b_q;
               OP_AND: r_d = a_q & b_q;
               OP_OR:  r_d = a_q | b_q;
               OP_XOR: r_d = a_q ^ b_q;
               OP_SHL: r_d = a_q << b_q[3:0];
               OP_LDI: r_d = imm_q;
               OP_MUL: begin
`ifdef RF_EXEC_MUL_EN
                  prod_d   = '0;
                  mcand_d  = a_q;
                  mplier_d = b_q;
                  cnt_d    = '0;
                  state_d  = MUL;
`else
                  Error   = 1'b1;
                  state_d = IDLE;
`endif
               end
            endcase
         end
`ifdef RF_EXEC_MUL_EN
         MUL: begin
            prod_d   = mplier_q[0] ? (prod_q + mcand_q) : prod_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            // final step hands the completed product straight to R
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               r_d     = prod_d;
               state_d = WB;
            end
         end
`endif
         WB: begin
            Write_Enable = 1'b1;
            Done         = 1'b1;
            zero_d       = (r_q == '0);
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously by Reset
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         dest_q   <= '0;
         src1_q   <= '0;
         src2_q   <= '0;
         imm_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         r_q      <= '0;
         zero_q   <= 1'b0;
`ifdef RF_EXEC_MUL_EN
         prod_q   <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         dest_q   <= dest_d;
         src1_q   <= src1_d;
         src2_q   <= src2_d;
         imm_q    <= imm_d;
         a_q      <= a_d;
         b_q      <= b_d;
         r_q      <= r_d;
         zero_q   <= zero_d;
`ifdef RF_EXEC_MUL_EN
         prod_q   <= prod_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
`endif
      end
   end

endmodule
